// File: rtl/rv32i_types.sv
// Shared types for the memory-side path: cacheline geometry and burst FSM encoding.
package rv32i_types;

    localparam int CACHELINE_BITS = 256;
    localparam int BURST_BEATS    = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        R_ISSUE = 3'd1,
        R_WAIT  = 3'd2,
        W_BURST = 3'd3,
        RESP    = 3'd4
    } burst_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit line request into a 4x64-bit burst; one request in flight.
// Latency: write 4 beats + 1 RESP cycle; read 1 issue + mem latency + 4 beats + 1 RESP cycle.
// Backpressure: bmem_ready stalls the issue and the write beats; read beats may arrive with gaps.
module cacheline_adapter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = CACHELINE_BITS,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFS_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << OFS_W) - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    burst_state_t                   state_q, state_d;
    logic [CNT_W-1:0]               beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]              addr_q;
    logic                           is_write_q;
    logic [BEATS-1:0][BEAT_W-1:0]   wline_q;
    logic [BEATS-1:0][BEAT_W-1:0]   line_buf_q;
    logic                           rbeat_take;
    logic                           wbeat_take;

    // Beats tagged for another line (or outside R_WAIT) are silently dropped.
    assign rbeat_take = (state_q == R_WAIT) && bmem_rvalid && (bmem_raddr == addr_q);
    assign wbeat_take = (state_q == W_BURST) && bmem_ready;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (dfp_write)     state_d = W_BURST;
                else if (dfp_read) state_d = R_ISSUE;
            end
            R_ISSUE: begin
                if (bmem_ready) state_d = R_WAIT;
            end
            R_WAIT: begin
                if (rbeat_take) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) state_d = RESP;
                end
            end
            W_BURST: begin
                if (wbeat_take) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            is_write_q <= 1'b0;
            wline_q    <= '0;
            line_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            if ((state_q == IDLE) && (dfp_read || dfp_write)) begin
                addr_q     <= dfp_addr & ~OFS_MASK;
                is_write_q <= dfp_write;
                if (dfp_write) wline_q <= dfp_wdata;
            end
            if (rbeat_take) line_buf_q[beat_cnt_q] <= bmem_rdata;
        end
    end

    assign bmem_addr  = addr_q;
    assign bmem_read  = (state_q == R_ISSUE);
    assign bmem_write = (state_q == W_BURST);
    assign bmem_wdata = bmem_write ? wline_q[beat_cnt_q] : '0;
    assign dfp_resp   = (state_q == RESP);
    assign dfp_rdata  = (dfp_resp && !is_write_q) ? line_buf_q : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboarded bench for cacheline_adapter: expected beats/lines queued at stimulus, checked at output.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read, dfp_write;
    logic [255:0] dfp_wdata, dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read, bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    cacheline_adapter dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    int            rd_hi, rd_acc;
    logic [31:0]   exp_addr;
    logic [63:0]   beat_q[$];
    logic [255:0]  resp_q[$];

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sampled mid-cycle, while inputs are stable.
    task automatic mon();
        if (bmem_write) begin
            chk("w_addr", bmem_addr, exp_addr);
            if (beat_q.size() == 0) chk("w_extra_beat", 1, 0);
            else begin
                chk("w_beat", bmem_wdata, beat_q[0]);
                if (bmem_ready) void'(beat_q.pop_front());
            end
        end
        if (bmem_read) begin
            rd_hi++;
            chk("r_addr", bmem_addr, exp_addr);
            if (bmem_ready) rd_acc++;
        end
        if (dfp_resp) begin
            if (resp_q.size() == 0) chk("spurious_resp", 1, 0);
            else chk("rdata", dfp_rdata, resp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] tag, input logic [63:0] d);
        bmem_rvalid = 1'b1;
        bmem_raddr  = tag;
        bmem_rdata  = d;
        tick();
        bmem_rvalid = 1'b0;
    endtask

    task automatic start_read(input logic [31:0] a, input logic [255:0] line, input int stall);
        rd_hi = 0;
        rd_acc = 0;
        exp_addr = a & ~32'h1f;
        resp_q.push_back(line);
        dfp_addr = a;
        dfp_read = 1'b1;
        bmem_ready = 1'b0;
        tick();
        chk("r_issue", bmem_read, 1);
        repeat (stall) tick();
        bmem_ready = 1'b1;
        tick();
        chk("r_issue_cycles", rd_hi, stall + 1);
        chk("r_issue_accepts", rd_acc, 1);
        tick();
        tick();
    endtask

    task automatic finish_read();
        int n;
        n = 0;
        while (!dfp_resp && n < 20) begin
            tick();
            n++;
        end
        chk("r_resp_seen", dfp_resp, 1);
        dfp_read = 1'b0;
        tick();
        chk("r_resp_pulse", dfp_resp, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [255:0] line,
                           input int stall, input bit stale);
        start_read(a, line, stall);
        for (int k = 0; k < 4; k++) begin
            if (stale && k == 1) send_beat(32'h40, 64'hDEAD_BEEF_DEAD_BEEF);
            send_beat(a & ~32'h1f, line[64*k +: 64]);
        end
        finish_read();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] line, input int stall_n);
        int lat;
        exp_addr = a & ~32'h1f;
        for (int k = 0; k < 4; k++) beat_q.push_back(line[64*k +: 64]);
        resp_q.push_back('0);
        dfp_addr = a;
        dfp_wdata = line;
        dfp_write = 1'b1;
        lat = 0;
        while (!dfp_resp && lat < 30) begin
            // hold ready low while beat 1 is presented
            bmem_ready = !(lat >= 2 && lat < 2 + stall_n);
            tick();
            lat++;
        end
        chk("w_resp_seen", dfp_resp, 1);
        chk("w_latency", lat, 5 + stall_n);
        dfp_write = 1'b0;
        dfp_wdata = {4{64'h5A5A_5A5A_5A5A_5A5A}};
        tick();
        chk("w_resp_pulse", dfp_resp, 0);
        chk("w_beats_drained", beat_q.size(), 0);
    endtask

    logic [255:0] rline1, rline2, rline3, wline1, wline2;

    initial begin
        rst = 1'b1;
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        exp_addr = '0;
        rline1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        rline2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'hCAFE_F00D_0000_0001, 64'h8000_0000_0000_0007};
        rline3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        wline1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        wline2 = {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                  64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A};
        tick();
        tick();
        chk("reset_outputs", {dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata}, '0);
        rst = 1'b0;
        tick();

        do_read(32'h0000_1234, rline1, 0, 1'b0);
        do_write(32'h0000_5678, wline1, 0);
        do_write(32'h0000_9A1F, wline2, 3);
        do_read(32'h0000_1220, rline2, 0, 1'b1);
        do_read(32'h0000_0C00, rline3, 2, 1'b0);

        // reset after two read beats; the rest of the burst arrives late and must be ignored
        start_read(32'h0000_2000, rline2, 0);
        send_beat(32'h0000_2000, rline2[63:0]);
        send_beat(32'h0000_2000, rline2[127:64]);
        rst = 1'b1;
        dfp_read = 1'b0;
        resp_q.delete();
        tick();
        chk("midburst_reset_outputs",
            {dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata}, '0);
        rst = 1'b0;
        send_beat(32'h0000_2000, rline2[191:128]);
        send_beat(32'h0000_2000, rline2[255:192]);
        repeat (3) tick();
        chk("post_reset_idle", {dfp_resp, bmem_read, bmem_write}, 0);

        do_read(32'h0000_2008, rline1, 1, 1'b0);
        do_write(32'h0000_2000, wline1, 0);

        chk("resp_queue_empty", resp_q.size(), 0);
        chk("beat_queue_empty", beat_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
